ntt_input_loader: RTL and testbench

// - Upstream feeder for the parallel NTT core.
// - Accepts a serial stream of N-bit coefficients over a valid/ready handshake and reduces each one once modulo Q.
// - Assembles D coefficients per frame (optionally in bit-reversed order) into ping-pong banks.
// - Presents a stable D*N-bit frame until the core's load strobe consumes it.

---
 rtl/ntt_pkg.sv | 26 ++
 rtl/mod_reduce_once.sv | 19 +
 rtl/ntt_input_loader.sv | 110 +++++++++++
 tb/tb_ntt_input_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and index helpers for the NTT datapath and its feeders.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ntt_pkg;

    // Coefficient width, frame size, modulus and default slot ordering
    localparam int NTT_N      = 17;
    localparam int NTT_D      = 8;
    localparam int NTT_Q      = 65537;
    localparam int NTT_LOG2D  = $clog2(NTT_D);
    localparam int NTT_BITREV = 1;

    // Reverse the low log2d bits of idx; upper bits of the result are zero.
    // Shared with the twiddle-index generator so both sides agree on ordering.
    function automatic int bitrev(input int idx, input int log2d);
        int r;
        r = 0;
        for (int b = 0; b < 32; b++) begin
            if (b < log2d) begin
                r[log2d - 1 - b] = idx[b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_reduce_once.sv
// Single conditional subtract of Q; valid for inputs below 2*Q.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the input.
module mod_reduce_once #(
    parameter int N = 17,
    parameter int Q = 65537
) (
    input  logic [N-1:0] i_x,
    output logic [N-1:0] o_y
);

    localparam logic [N-1:0] QV = N'(Q);

    logic w_ge_q;

    assign w_ge_q = (i_x >= QV);
    assign o_y    = w_ge_q ? (i_x - QV) : i_x;

endmodule

// File: rtl/ntt_input_loader.sv
// Serial-to-parallel coefficient loader: reduce mod Q, place into ping-pong frame banks.
// Latency: completing beat at edge t -> frame visible after edge t (one cycle).
// Backpressure: s_ready drops only when the write bank is still full; frame held until taken.
module ntt_input_loader
    import ntt_pkg::*;
#(
    parameter int N      = NTT_N,
    parameter int D      = NTT_D,
    parameter int Q      = NTT_Q,
    parameter int BITREV = NTT_BITREV
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_s_coef,
    input  logic           i_s_valid,
    input  logic           i_s_last,
    output logic           o_s_ready,
    output logic [D*N-1:0] o_frame_out,
    output logic           o_frame_valid,
    input  logic           i_frame_take,
    output logic           o_short_frame
);

    localparam int              LOG2D  = $clog2(D);
    localparam logic [LOG2D-1:0] K_LAST = LOG2D'(D - 1);

    // Storage slot used for beat index j of a frame
    function automatic logic [LOG2D-1:0] slot_of(input int j);
        if (BITREV != 0) begin
            return LOG2D'(bitrev(j, LOG2D));
        end
        return LOG2D'(j);
    endfunction

    logic [D-1:0][N-1:0] r_bank [2];
    logic [1:0]          r_full;
    logic                r_wr_sel;
    logic                r_rd_sel;
    logic [LOG2D-1:0]    r_k;
    logic                r_short;

    logic [N-1:0]        w_coef_red;
    logic                w_xfer;
    logic                w_done;
    logic                w_early;
    logic                w_take;

    mod_reduce_once #(
        .N (N),
        .Q (Q)
    ) u_reduce (
        .i_x (i_s_coef),
        .o_y (w_coef_red)
    );

    // Ready depends only on registered state so upstream sees no comb loop
    assign o_s_ready = ~r_full[r_wr_sel];
    assign w_xfer    = i_s_valid & o_s_ready;
    assign w_early   = w_xfer & i_s_last & (r_k != K_LAST);
    assign w_done    = w_xfer & (i_s_last | (r_k == K_LAST));
    // A take with nothing to read is dropped
    assign w_take    = i_frame_take & r_full[r_rd_sel];

    // Write the reduced beat into its slot; an early last zero-fills the remaining slots
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bank[0] <= '0;
            r_bank[1] <= '0;
        end else if (w_xfer) begin
            for (int j = 0; j < D; j++) begin
                if (LOG2D'(j) == r_k) begin
                    r_bank[r_wr_sel][slot_of(j)] <= w_coef_red;
                end else if (w_early && (LOG2D'(j) > r_k)) begin
                    r_bank[r_wr_sel][slot_of(j)] <= '0;
                end
            end
        end
    end

    // Beat counter, bank ownership and the short-frame flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_full   <= 2'b00;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_k      <= '0;
            r_short  <= 1'b0;
        end else begin
            r_short <= w_early;
            if (w_xfer) begin
                r_k <= w_done ? '0 : r_k + 1'b1;
            end
            // Fill and drain never target the same bank in one cycle:
            // filling needs the write bank empty, draining needs the read bank full.
            if (w_done) begin
                r_full[r_wr_sel] <= 1'b1;
                r_wr_sel         <= ~r_wr_sel;
            end
            if (w_take) begin
                r_full[r_rd_sel] <= 1'b0;
                r_rd_sel         <= ~r_rd_sel;
            end
        end
    end

    assign o_frame_out   = r_bank[r_rd_sel];
    assign o_frame_valid = r_full[r_rd_sel];
    assign o_short_frame = r_short;

endmodule

// File: tb/tb_ntt_input_loader.sv
// Directed bench for ntt_input_loader; two instances (bit-reversed and natural order) share stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_ntt_input_loader;

    localparam int N = 17;
    localparam int D = 8;
    localparam int Q = 65537;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   s_coef = '0;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic           frame_take = 1'b0;

    logic           s_ready, frame_valid, short_frame;
    logic [D*N-1:0] frame_out;
    logic           s_ready0, frame_valid0, short_frame0;
    logic [D*N-1:0] frame_out0;

    int checks = 0;
    int failures = 0;
    int brt [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    always #5 clk = ~clk;

    ntt_input_loader #(.N(N), .D(D), .Q(Q), .BITREV(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_s_coef(s_coef), .i_s_valid(s_valid),
        .i_s_last(s_last), .o_s_ready(s_ready), .o_frame_out(frame_out),
        .o_frame_valid(frame_valid), .i_frame_take(frame_take), .o_short_frame(short_frame)
    );

    ntt_input_loader #(.N(N), .D(D), .Q(Q), .BITREV(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_s_coef(s_coef), .i_s_valid(s_valid),
        .i_s_last(s_last), .o_s_ready(s_ready0), .o_frame_out(frame_out0),
        .o_frame_valid(frame_valid0), .i_frame_take(frame_take), .o_short_frame(short_frame0)
    );

    // Expected frame from per-beat values; br selects bit-reversed placement
    function automatic logic [D*N-1:0] mk(input int vals [8], input bit br);
        logic [D*N-1:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[N * (br ? brt[k] : k) +: N] = N'(vals[k]);
        end
        return r;
    endfunction

    function automatic logic [D*N-1:0] mkseq(input int base, input bit br);
        int v [8];
        for (int k = 0; k < 8; k++) v[k] = base + k;
        return mk(v, br);
    endfunction

    // Entered and left just after a rising edge; waits (bounded) for ready
    task automatic send_beat(input int c, input bit last);
        int n;
        s_valid = 1'b1;
        s_coef  = N'(c);
        s_last  = last;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            failures++;
            $display("FAIL send_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, n);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic take_frame();
        frame_take = 1'b1;
        @(posedge clk);
        #1;
        frame_take = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b want 1", s_ready); end
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", frame_valid); end
        checks++; if (frame_out !== '0) begin failures++; $display("FAIL reset_frame: got %h want 0", frame_out); end
        checks++; if (short_frame !== 1'b0) begin failures++; $display("FAIL reset_short: got %0b want 0", short_frame); end
        checks++; if (frame_valid0 !== 1'b0 || frame_out0 !== '0) begin failures++; $display("FAIL reset_dut0: valid=%0b frame=%h want 0/0", frame_valid0, frame_out0); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bitrev_frame();
        for (int k = 0; k < 7; k++) send_beat(k, 1'b0);
        @(negedge clk);
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL bitrev_early_valid: got %0b want 0", frame_valid); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bitrev_ready: got %0b want 1", s_ready); end
        @(posedge clk);
        #1;
        send_beat(7, 1'b0);
        @(negedge clk);
        checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL bitrev_valid: got %0b want 1", frame_valid); end
        checks++; if (frame_out !== mkseq(0, 1'b1)) begin failures++; $display("FAIL bitrev_frame: got %h want %h", frame_out, mkseq(0, 1'b1)); end
        checks++; if (frame_out0 !== mkseq(0, 1'b0)) begin failures++; $display("FAIL natural_frame: got %h want %h", frame_out0, mkseq(0, 1'b0)); end
        checks++; if (short_frame !== 1'b0) begin failures++; $display("FAIL full_no_short: got %0b want 0", short_frame); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bitrev_ready_after: got %0b want 1", s_ready); end
        @(posedge clk);
        #1;
        take_frame();
        @(negedge clk);
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL bitrev_taken: got %0b want 0", frame_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reduction();
        int v [8];
        v = '{0, 1, 65534, 5, 0, 0, 0, 0};
        send_beat(65537, 1'b0);
        send_beat(65538, 1'b0);
        send_beat(131071, 1'b0);
        send_beat(5, 1'b1);
        @(negedge clk);
        checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL reduce_valid: got %0b want 1", frame_valid); end
        checks++; if (frame_out !== mk(v, 1'b1)) begin failures++; $display("FAIL reduce_frame: got %h want %h", frame_out, mk(v, 1'b1)); end
        checks++; if (short_frame !== 1'b1) begin failures++; $display("FAIL reduce_short: got %0b want 1", short_frame); end
        @(negedge clk);
        checks++; if (short_frame !== 1'b0) begin failures++; $display("FAIL reduce_short_clear: got %0b want 0", short_frame); end
        @(posedge clk);
        #1;
        take_frame();
    endtask

    task automatic test_short_frame();
        int v [8];
        v = '{10, 20, 30, 0, 0, 0, 0, 0};
        send_beat(10, 1'b0);
        send_beat(20, 1'b0);
        @(negedge clk);
        checks++; if (short_frame0 !== 1'b0) begin failures++; $display("FAIL short_before: got %0b want 0", short_frame0); end
        @(posedge clk);
        #1;
        send_beat(30, 1'b1);
        @(negedge clk);
        checks++; if (short_frame0 !== 1'b1) begin failures++; $display("FAIL short_pulse: got %0b want 1", short_frame0); end
        checks++; if (frame_valid0 !== 1'b1) begin failures++; $display("FAIL short_valid: got %0b want 1", frame_valid0); end
        checks++; if (frame_out0 !== mk(v, 1'b0)) begin failures++; $display("FAIL short_frame0: got %h want %h", frame_out0, mk(v, 1'b0)); end
        checks++; if (frame_out !== mk(v, 1'b1)) begin failures++; $display("FAIL short_frame_br: got %h want %h", frame_out, mk(v, 1'b1)); end
        @(negedge clk);
        checks++; if (short_frame0 !== 1'b0) begin failures++; $display("FAIL short_once: got %0b want 0", short_frame0); end
        @(posedge clk);
        #1;
        take_frame();
    endtask

    task automatic test_backpressure();
        for (int f = 1; f <= 2; f++)
            for (int k = 0; k < 8; k++) send_beat(100 * f + k, 1'b0);
        s_valid = 1'b1;
        s_coef  = N'(300);
        repeat (3) begin
            @(negedge clk);
            checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low: got %0b want 0", s_ready); end
            checks++; if (frame_out !== mkseq(100, 1'b1)) begin failures++; $display("FAIL bp_hold_f1: got %h want %h", frame_out, mkseq(100, 1'b1)); end
        end
        @(posedge clk);
        #1;
        frame_take = 1'b1;
        @(posedge clk);
        #1;
        frame_take = 1'b0;
        @(negedge clk);
        checks++; if (frame_out !== mkseq(200, 1'b1)) begin failures++; $display("FAIL bp_f2: got %h want %h", frame_out, mkseq(200, 1'b1)); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back: got %0b want 1", s_ready); end
        checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_f2: got %0b want 1", frame_valid); end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        for (int k = 1; k < 8; k++) send_beat(300 + k, 1'b0);
        @(negedge clk);
        checks++; if (s_ready !== 1'b0 || frame_out !== mkseq(200, 1'b1)) begin failures++; $display("FAIL bp_full_again: ready=%0b frame=%h want 0/%h", s_ready, frame_out, mkseq(200, 1'b1)); end
        @(posedge clk);
        #1;
        take_frame();
        @(negedge clk);
        checks++; if (frame_out !== mkseq(300, 1'b1) || frame_valid !== 1'b1) begin failures++; $display("FAIL bp_f3: valid=%0b frame=%h want 1/%h", frame_valid, frame_out, mkseq(300, 1'b1)); end
        @(posedge clk);
        #1;
        take_frame();
        @(negedge clk);
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL bp_drained: got %0b want 0", frame_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_take_idle_and_overlap();
        take_frame();
        @(negedge clk);
        checks++; if (frame_valid !== 1'b0 || s_ready !== 1'b1) begin failures++; $display("FAIL idle_take_flags: valid=%0b ready=%0b want 0/1", frame_valid, s_ready); end
        checks++; if (frame_out !== mkseq(200, 1'b1)) begin failures++; $display("FAIL idle_take_retained: got %h want %h", frame_out, mkseq(200, 1'b1)); end
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) send_beat(400 + k, 1'b0);
        @(negedge clk);
        checks++; if (frame_valid !== 1'b1 || frame_out !== mkseq(400, 1'b1)) begin failures++; $display("FAIL idle_next_frame: valid=%0b frame=%h want 1/%h", frame_valid, frame_out, mkseq(400, 1'b1)); end
        @(posedge clk);
        #1;
        for (int k = 0; k < 7; k++) send_beat(500 + k, 1'b0);
        s_valid    = 1'b1;
        s_coef     = N'(507);
        frame_take = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL overlap_ready: got %0b want 1", s_ready); end
        @(posedge clk);
        #1;
        s_valid    = 1'b0;
        frame_take = 1'b0;
        @(negedge clk);
        checks++; if (frame_valid !== 1'b1 || frame_out !== mkseq(500, 1'b1)) begin failures++; $display("FAIL overlap_frame: valid=%0b frame=%h want 1/%h", frame_valid, frame_out, mkseq(500, 1'b1)); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL overlap_ready_after: got %0b want 1", s_ready); end
        @(posedge clk);
        #1;
        take_frame();
        @(negedge clk);
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL overlap_drained: got %0b want 0", frame_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 5; k++) send_beat(600 + k, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1 || frame_valid !== 1'b0) begin failures++; $display("FAIL midrst_flags: ready=%0b valid=%0b want 1/0", s_ready, frame_valid); end
        checks++; if (frame_out !== '0) begin failures++; $display("FAIL midrst_frame: got %h want 0", frame_out); end
        checks++; if (short_frame !== 1'b0) begin failures++; $display("FAIL midrst_short: got %0b want 0", short_frame); end
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) send_beat(700 + k, 1'b0);
        @(negedge clk);
        checks++; if (frame_valid !== 1'b1 || frame_out !== mkseq(700, 1'b1)) begin failures++; $display("FAIL midrst_reload: valid=%0b frame=%h want 1/%h", frame_valid, frame_out, mkseq(700, 1'b1)); end
        checks++; if (frame_out0 !== mkseq(700, 1'b0)) begin failures++; $display("FAIL midrst_reload0: got %h want %h", frame_out0, mkseq(700, 1'b0)); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_bitrev_frame();
        test_reduction();
        test_short_frame();
        test_backpressure();
        test_take_idle_and_overlap();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
